fifo_wr_arbiter: RTL and testbench

Round-robin arbiter that shares the single write port of the team's `async_fifo` among `NUM_REQ` requesters in the write-clock domain. Each requester presents valid/data and receives a ready. The arbiter grants one requester at a time for a burst of up to `MAX_BURST` words and gates every write against the FIFO full flag. It sits directly in front of `async_fifo` (`i_wr_clk` side) and drives its `i_wr_en`/`i_wr_data`.

---
 rtl/fifo_arb_pkg.sv | 20 ++
 rtl/rr_pick.sv | 39 +++
 rtl/fifo_wr_arbiter.sv | 121 ++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_arb_pkg.sv
// Shared definitions for the async_fifo write-port arbiter.
package fifo_arb_pkg;

    // Arbiter FSM encoding.
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } arb_state_e;

    // Bits needed to hold values 0..value-1; never narrower than one bit.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned width;
        width = 1;
        while ((64'd1 << width) < 64'(value)) begin
            width++;
        end
        return width;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotate-priority encoder: first valid index at or after the round-robin pointer.
module rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned IDX_W   = clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req_valid,
    input  logic [IDX_W-1:0]   i_rr_ptr,
    output logic [IDX_W-1:0]   o_sel,
    output logic               o_any
);

    logic [2*NUM_REQ-1:0] doubled;
    logic [NUM_REQ-1:0]   rotated;
    logic [IDX_W-1:0]     offset;
    logic [IDX_W:0]       sum;

    // Rotating the doubled vector puts the pointer position at bit 0.
    assign doubled = {i_req_valid, i_req_valid} >> i_rr_ptr;
    assign rotated = doubled[NUM_REQ-1:0];

    // Lowest set bit of the rotated vector, mapped back to a requester index.
    always_comb begin
        offset = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (rotated[i]) begin
                offset = IDX_W'(i);
            end
        end
        sum = {1'b0, i_rr_ptr} + {1'b0, offset};
        if (sum >= (IDX_W + 1)'(NUM_REQ)) begin
            sum = sum - (IDX_W + 1)'(NUM_REQ);
        end
        o_sel = sum[IDX_W-1:0];
        o_any = |i_req_valid;
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing the async_fifo write port among NUM_REQ requesters.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 4,
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned MAX_BURST  = 4,
    localparam int unsigned IDX_W     = clog2(NUM_REQ),
    localparam int unsigned CNT_W     = clog2(MAX_BURST + 1)
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic [NUM_REQ-1:0]            i_req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] i_req_data,
    output logic [NUM_REQ-1:0]            o_req_ready,
    input  logic                          i_fifo_full,
    output logic                          o_fifo_wr_en,
    output logic [DATA_WIDTH-1:0]         o_fifo_wr_data,
    output logic [IDX_W-1:0]              o_grant_id,
    output logic                          o_busy
);

    arb_state_e            state_q, state_d;
    logic [IDX_W-1:0]      grant_q, grant_d;
    logic [IDX_W-1:0]      rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]      beat_q, beat_d;

    logic [IDX_W-1:0]      pick_idx;
    logic                  pick_any;
    logic                  grant_valid;
    logic                  xfer;
    logic [CNT_W-1:0]      beat_inc;
    logic [IDX_W-1:0]      ptr_after;
    logic [DATA_WIDTH-1:0] req_words [NUM_REQ];

    for (genvar k = 0; k < NUM_REQ; k++) begin : g_words
        assign req_words[k] = i_req_data[k*DATA_WIDTH +: DATA_WIDTH];
    end

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_pick (
        .i_req_valid (i_req_valid),
        .i_rr_ptr    (rr_ptr_q),
        .o_sel       (pick_idx),
        .o_any       (pick_any)
    );

    assign grant_valid = i_req_valid[grant_q];
    assign xfer        = (state_q == ST_BURST) & grant_valid & ~i_fifo_full;
    assign beat_inc    = beat_q + CNT_W'(1);
    assign ptr_after   = (grant_q == IDX_W'(NUM_REQ - 1)) ? '0 : grant_q + IDX_W'(1);

    // State register.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Grant, round-robin pointer and beat counter registers.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            grant_q  <= '0;
            rr_ptr_q <= '0;
            beat_q   <= '0;
        end else begin
            grant_q  <= grant_d;
            rr_ptr_q <= rr_ptr_d;
            beat_q   <= beat_d;
        end
    end

    // Next state: arbitrate in IDLE, count beats and detect burst end in BURST.
    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        rr_ptr_d = rr_ptr_q;
        beat_d   = beat_q;
        unique case (state_q)
            ST_IDLE: begin
                if (pick_any) begin
                    grant_d = pick_idx;
                    beat_d  = '0;
                    state_d = ST_BURST;
                end
            end
            ST_BURST: begin
                // A dropped valid ends the burst even when full is also high.
                if (!grant_valid) begin
                    state_d  = ST_IDLE;
                    rr_ptr_d = ptr_after;
                end else if (xfer) begin
                    beat_d = beat_inc;
                    if (beat_inc == CNT_W'(MAX_BURST)) begin
                        state_d  = ST_IDLE;
                        rr_ptr_d = ptr_after;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs: only the grant holder sees ready; writes are gated by full.
    always_comb begin
        o_req_ready = '0;
        // Reset suppresses the write in the cycle it is applied.
        if (state_q == ST_BURST && i_rst_n) begin
            o_req_ready[grant_q] = ~i_fifo_full;
        end
        o_fifo_wr_en   = xfer & i_rst_n;
        o_fifo_wr_data = req_words[grant_q];
        o_grant_id     = grant_q;
        o_busy         = (state_q == ST_BURST);
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: vector table, corner sequences, random vs model.
module tb_fifo_wr_arbiter;

    localparam int DW = 4;
    localparam int NR = 4;
    localparam int MB = 4;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [NR-1:0]  req_valid;
    logic [NR*DW-1:0] req_data;
    logic [NR-1:0]  req_ready;
    logic           fifo_full;
    logic           wr_en;
    logic [DW-1:0]  wr_data;
    logic [1:0]     grant_id;
    logic           busy;

    int cmp_cnt = 0;
    int err_cnt = 0;

    always #5 clk = ~clk;

    fifo_wr_arbiter #(
        .DATA_WIDTH (DW),
        .NUM_REQ    (NR),
        .MAX_BURST  (MB)
    ) dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_req_valid    (req_valid),
        .i_req_data     (req_data),
        .o_req_ready    (req_ready),
        .i_fifo_full    (fifo_full),
        .o_fifo_wr_en   (wr_en),
        .o_fifo_wr_data (wr_data),
        .o_grant_id     (grant_id),
        .o_busy         (busy)
    );

    typedef struct {
        logic [3:0]  valid;
        logic [15:0] data;
        logic        full;
        logic [3:0]  ready;
        logic        wr;
        logic [3:0]  wdata;
        logic        busy;
        logic [1:0]  grant;
    } vec_t;

    localparam int NV = 24;
    vec_t vecs [NV];

    function automatic vec_t mk(input logic [3:0] v, input logic [15:0] d, input logic f,
                                input logic [3:0] r, input logic w, input logic [3:0] wd,
                                input logic b, input logic [1:0] g);
        vec_t x;
        x.valid = v; x.data = d; x.full = f;
        x.ready = r; x.wr = w; x.wdata = wd; x.busy = b; x.grant = g;
        return x;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        cmp_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        req_valid = '0;
        req_data  = '0;
        fifo_full = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] q0 [$];
        logic [3:0] q1 [$];
        logic [3:0] fq [$];
        logic [3:0] exp_fifo [8];
        int owner, sent, ptr;

        // valid, data, full | ready, wr, wdata, busy, grant
        vecs[0]  = mk(4'b0000, 16'h0000, 0, 4'b0000, 0, 4'h0, 0, 2'd0);
        vecs[1]  = mk(4'b0100, 16'h0500, 0, 4'b0000, 0, 4'h0, 0, 2'd0);
        vecs[2]  = mk(4'b0100, 16'h0500, 0, 4'b0100, 1, 4'h5, 1, 2'd2);
        vecs[3]  = mk(4'b0100, 16'h0600, 0, 4'b0100, 1, 4'h6, 1, 2'd2);
        vecs[4]  = mk(4'b0100, 16'h0700, 0, 4'b0100, 1, 4'h7, 1, 2'd2);
        vecs[5]  = mk(4'b0000, 16'h0000, 0, 4'b0100, 0, 4'h0, 1, 2'd2);
        vecs[6]  = mk(4'b1111, 16'h9abc, 0, 4'b0000, 0, 4'h0, 0, 2'd0);
        vecs[7]  = mk(4'b1111, 16'h9abc, 0, 4'b1000, 1, 4'h9, 1, 2'd3);
        vecs[8]  = mk(4'b0000, 16'h0000, 0, 4'b1000, 0, 4'h0, 1, 2'd3);
        vecs[9]  = mk(4'b0001, 16'h0003, 0, 4'b0000, 0, 4'h0, 0, 2'd0);
        vecs[10] = mk(4'b0001, 16'h0003, 0, 4'b0001, 1, 4'h3, 1, 2'd0);
        vecs[11] = mk(4'b0000, 16'h0000, 1, 4'b0000, 0, 4'h0, 1, 2'd0);
        vecs[12] = mk(4'b1111, 16'h4321, 0, 4'b0000, 0, 4'h0, 0, 2'd0);
        vecs[13] = mk(4'b1111, 16'h4321, 0, 4'b0010, 1, 4'h2, 1, 2'd1);
        vecs[14] = mk(4'b0010, 16'h0050, 0, 4'b0010, 1, 4'h5, 1, 2'd1);
        vecs[15] = mk(4'b0010, 16'h0060, 1, 4'b0000, 0, 4'h0, 1, 2'd1);
        vecs[16] = mk(4'b0010, 16'h0060, 1, 4'b0000, 0, 4'h0, 1, 2'd1);
        vecs[17] = mk(4'b0010, 16'h0060, 1, 4'b0000, 0, 4'h0, 1, 2'd1);
        vecs[18] = mk(4'b0010, 16'h0060, 0, 4'b0010, 1, 4'h6, 1, 2'd1);
        vecs[19] = mk(4'b0010, 16'h0070, 1, 4'b0000, 0, 4'h0, 1, 2'd1);
        vecs[20] = mk(4'b0010, 16'h0070, 0, 4'b0010, 1, 4'h7, 1, 2'd1);
        vecs[21] = mk(4'b0010, 16'h0080, 0, 4'b0000, 0, 4'h0, 0, 2'd0);
        vecs[22] = mk(4'b0000, 16'h0000, 0, 4'b0010, 0, 4'h0, 1, 2'd1);
        vecs[23] = mk(4'b0000, 16'h0000, 0, 4'b0000, 0, 4'h0, 0, 2'd0);

        // Table: single requester, pointer wrap, valid drop with full, full stall.
        do_reset();
        for (int i = 0; i < NV; i++) begin
            req_valid = vecs[i].valid;
            req_data  = vecs[i].data;
            fifo_full = vecs[i].full;
            #1;
            check($sformatf("vec%0d_ready", i), 32'(req_ready), 32'(vecs[i].ready));
            check($sformatf("vec%0d_wr_en", i), 32'(wr_en), 32'(vecs[i].wr));
            check($sformatf("vec%0d_busy", i), 32'(busy), 32'(vecs[i].busy));
            if (vecs[i].busy) check($sformatf("vec%0d_grant", i), 32'(grant_id), 32'(vecs[i].grant));
            if (vecs[i].wr) check($sformatf("vec%0d_wdata", i), 32'(wr_data), 32'(vecs[i].wdata));
            @(negedge clk);
        end

        // Fairness: all valid, bursts of MB words separated by one idle cycle.
        do_reset();
        req_valid = 4'b1111;
        req_data  = 16'h3210;
        for (int c = 0; c < 5 * (MB + 1); c++) begin
            #1;
            if (c % (MB + 1) == 0) begin
                check("rr_idle_busy", 32'(busy), 32'd0);
                check("rr_idle_wr", 32'(wr_en), 32'd0);
            end else begin
                check("rr_busy", 32'(busy), 32'd1);
                check("rr_grant", 32'(grant_id), 32'((c / (MB + 1)) % NR));
                check("rr_wr", 32'(wr_en), 32'd1);
                check("rr_wdata", 32'(wr_data), 32'((c / (MB + 1)) % NR));
            end
            @(negedge clk);
        end

        // Reset in the middle of a burst from requester 3.
        do_reset();
        req_valid = 4'b1000;
        req_data  = 16'h1000;
        @(negedge clk);
        #1;
        check("mid_busy", 32'(busy), 32'd1);
        check("mid_grant", 32'(grant_id), 32'd3);
        check("mid_beat1_wr", 32'(wr_en), 32'd1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid_rst_cycle_wr", 32'(wr_en), 32'd0);
        check("mid_rst_cycle_ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        req_valid = 4'b1111;
        #1;
        check("mid_after_busy", 32'(busy), 32'd0);
        check("mid_after_wr", 32'(wr_en), 32'd0);
        check("mid_after_ready", 32'(req_ready), 32'd0);
        check("mid_after_grant", 32'(grant_id), 32'd0);
        @(negedge clk);
        #1;
        check("mid_next_grant", 32'(grant_id), 32'd0);
        check("mid_next_busy", 32'(busy), 32'd1);
        @(negedge clk);

        // Depth-8 FIFO with idle read side; requesters 0 and 1 send 8 words each.
        do_reset();
        for (int k = 0; k < 8; k++) begin
            q0.push_back(4'(k));
            q1.push_back(4'(k + 8));
        end
        for (int c = 0; c < 60; c++) begin
            logic [3:0] rdy;
            logic [3:0] vld;
            logic       w;
            logic [3:0] wd;
            vld = {2'b00, q1.size() > 0, q0.size() > 0};
            req_valid = vld;
            req_data  = {8'h00, (q1.size() > 0) ? q1[0] : 4'h0, (q0.size() > 0) ? q0[0] : 4'h0};
            fifo_full = (fq.size() >= 8);
            #1;
            rdy = req_ready;
            w   = wr_en;
            wd  = wr_data;
            if (w && fifo_full) check("int_write_while_full", 32'(w), 32'd0);
            if (w) fq.push_back(wd);
            if (rdy[0] && vld[0]) void'(q0.pop_front());
            if (rdy[1] && vld[1]) void'(q1.pop_front());
            @(negedge clk);
        end
        exp_fifo = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h8, 4'h9, 4'hA, 4'hB};
        check("int_fifo_count", 32'(fq.size()), 32'd8);
        check("int_q0_left", 32'(q0.size()), 32'd4);
        check("int_q1_left", 32'(q1.size()), 32'd4);
        for (int k = 0; k < 8; k++) begin
            if (fq.size() > 0) check($sformatf("int_read%0d", k), 32'(fq.pop_front()), 32'(exp_fifo[k]));
        end

        // Random traffic against a transaction-level model.
        do_reset();
        owner = -1;
        sent  = 0;
        ptr   = 0;
        for (int c = 0; c < 2000; c++) begin
            logic [3:0] nv;
            logic [3:0] er;
            logic       ew;
            logic [15:0] shifted;
            rst_n = ($urandom_range(63) != 0);
            for (int k = 0; k < NR; k++) begin
                if (req_valid[k]) nv[k] = ($urandom_range(7) != 0);
                else nv[k] = ($urandom_range(2) == 0);
            end
            req_valid = nv;
            req_data  = 16'($urandom);
            fifo_full = ($urandom_range(3) == 0);
            #1;
            er = '0;
            ew = 1'b0;
            if (owner >= 0 && rst_n) begin
                er[owner] = ~fifo_full;
                ew = req_valid[owner] & ~fifo_full;
            end
            check("rnd_busy", 32'(busy), 32'(owner >= 0));
            check("rnd_ready", 32'(req_ready), 32'(er));
            check("rnd_wr_en", 32'(wr_en), 32'(ew));
            if (owner >= 0) check("rnd_grant", 32'(grant_id), 32'(owner));
            if (ew) begin
                shifted = req_data >> (owner * DW);
                check("rnd_wdata", 32'(wr_data), 32'(shifted[3:0]));
            end
            // Advance the model across the clock edge.
            if (!rst_n) begin
                owner = -1;
                sent  = 0;
                ptr   = 0;
            end else if (owner < 0) begin
                for (int k = 0; k < NR; k++) begin
                    if (owner < 0 && req_valid[(ptr + k) % NR]) begin
                        owner = (ptr + k) % NR;
                        sent  = 0;
                    end
                end
            end else if (!req_valid[owner]) begin
                ptr   = (owner + 1) % NR;
                owner = -1;
            end else if (!fifo_full) begin
                sent++;
                if (sent == MB) begin
                    ptr   = (owner + 1) % NR;
                    owner = -1;
                end
            end
            @(negedge clk);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
